// File: rtl/fn1_mul_pipe_hs.sv
// Pipelined multiplier with valid/ready handshake, per-operand signedness and configurable depth.
// Optional saturation of narrowed products via `FN1_MUL_PIPE_HS_SAT_EN.
module fn1_mul_pipe_hs #(
    parameter int A_WIDTH   = 11,
    parameter int B_WIDTH   = 9,
    parameter int P_WIDTH   = 20,
    parameter bit A_SIGNED  = 1'b0,
    parameter bit B_SIGNED  = 1'b0,
    parameter int NUM_STAGE = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] din0,
    input  logic [B_WIDTH-1:0] din1,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [P_WIDTH-1:0] dout
);

    localparam int          W          = A_WIDTH + B_WIDTH;
    localparam int unsigned NP         = NUM_STAGE - 2;
    localparam bit          RES_SIGNED = A_SIGNED | B_SIGNED;

    logic               stall;
    logic               v1_q;
    logic [A_WIDTH-1:0] a_q;
    logic [B_WIDTH-1:0] b_q;
    logic [W-1:0]       a_x;
    logic [W-1:0]       b_x;
    logic [W-1:0]       prod_comb;
    logic [W-1:0]       last_prod;
    logic               last_v;
    logic [P_WIDTH-1:0] mapped;
    logic [P_WIDTH-1:0] dout_q;
    logic               ov_q;

    assign stall     = ~ce | (ov_q & ~out_ready);
    assign in_ready  = ~stall;
    assign out_valid = ov_q;
    assign dout      = dout_q;

    // Extending both operands to W bits makes the low W bits of a plain multiply exact.
    assign a_x       = {{B_WIDTH{A_SIGNED & a_q[A_WIDTH-1]}}, a_q};
    assign b_x       = {{A_WIDTH{B_SIGNED & b_q[B_WIDTH-1]}}, b_q};
    assign prod_comb = a_x * b_x;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q <= 1'b0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (!stall) begin
            v1_q <= in_valid;
            if (in_valid) begin
                a_q <= din0;
                b_q <= din1;
            end
        end
    end

    generate
        if (NP > 0) begin : g_prod
            logic [W-1:0] prod_q [NP];
            logic         pv_q   [NP];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int unsigned i = 0; i < NP; i++) begin
                        prod_q[i] <= '0;
                        pv_q[i]   <= 1'b0;
                    end
                end else if (!stall) begin
                    pv_q[0] <= v1_q;
                    if (v1_q) prod_q[0] <= prod_comb;
                    for (int unsigned i = 1; i < NP; i++) begin
                        pv_q[i] <= pv_q[i-1];
                        if (pv_q[i-1]) prod_q[i] <= prod_q[i-1];
                    end
                end
            end

            assign last_prod = prod_q[NP-1];
            assign last_v    = pv_q[NP-1];
        end else begin : g_noprod
            assign last_prod = prod_comb;
            assign last_v    = v1_q;
        end

        if (P_WIDTH > W) begin : g_ext
            assign mapped = {{(P_WIDTH-W){RES_SIGNED & last_prod[W-1]}}, last_prod};
        end else if (P_WIDTH == W) begin : g_same
            assign mapped = last_prod;
        end else begin : g_narrow
`ifdef FN1_MUL_PIPE_HS_SAT_EN
            // Signed result fits iff all bits from W-1 down to P_WIDTH-1 agree.
            always_comb begin
                mapped = last_prod[P_WIDTH-1:0];
                if (RES_SIGNED) begin
                    if (!(&last_prod[W-1:P_WIDTH-1]) && (|last_prod[W-1:P_WIDTH-1]))
                        mapped = last_prod[W-1] ? {1'b1, {(P_WIDTH-1){1'b0}}}
                                                : {1'b0, {(P_WIDTH-1){1'b1}}};
                end else if (|last_prod[W-1:P_WIDTH]) begin
                    mapped = '1;
                end
            end
`else
            logic unused_hi;
            assign unused_hi = ^last_prod[W-1:P_WIDTH];
            assign mapped    = last_prod[P_WIDTH-1:0];
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ov_q   <= 1'b0;
            dout_q <= '0;
        end else if (!stall) begin
            ov_q <= last_v;
            if (last_v) dout_q <= mapped;
        end
    end

endmodule

// File: tb/tb_fn1_mul_pipe_hs.sv
// Bench for fn1_mul_pipe_hs: four configurations share one stimulus stream, each checked
// against a queue-based arithmetic reference model plus directed latency/saturation cases.
module tb_fn1_mul_pipe_hs;

    localparam int NS [4] = '{4, 2, 3, 5};
    localparam int PW [4] = '{20, 20, 16, 16};
    localparam bit SG [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
`ifdef FN1_MUL_PIPE_HS_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        ce;
    logic        in_valid;
    logic        out_ready;
    logic [10:0] din0;
    logic [8:0]  din1;
    logic        ir [4];
    logic        ov [4];
    logic [19:0] dout0, dout1;
    logic [15:0] dout2, dout3;
    logic [19:0] dv [4];

    logic [19:0] expq [4][$];
    logic        hold_v [4];
    logic        prev_ov [4];
    logic [19:0] prev_dv [4];

    int checks = 0;
    int errors = 0;

    assign dv[0] = dout0;
    assign dv[1] = dout1;
    assign dv[2] = {4'b0, dout2};
    assign dv[3] = {4'b0, dout3};

    fn1_mul_pipe_hs u_d0 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(ir[0]),
        .din0(din0), .din1(din1), .out_valid(ov[0]), .out_ready(out_ready), .dout(dout0));

    fn1_mul_pipe_hs #(.A_SIGNED(1'b1), .B_SIGNED(1'b1), .NUM_STAGE(2)) u_d1 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(ir[1]),
        .din0(din0), .din1(din1), .out_valid(ov[1]), .out_ready(out_ready), .dout(dout1));

    fn1_mul_pipe_hs #(.P_WIDTH(16), .NUM_STAGE(3)) u_d2 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(ir[2]),
        .din0(din0), .din1(din1), .out_valid(ov[2]), .out_ready(out_ready), .dout(dout2));

    fn1_mul_pipe_hs #(.P_WIDTH(16), .A_SIGNED(1'b1), .B_SIGNED(1'b1), .NUM_STAGE(5)) u_d3 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(ir[3]),
        .din0(din0), .din1(din1), .out_valid(ov[3]), .out_ready(out_ready), .dout(dout3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] model(int k, logic [10:0] a, logic [8:0] b);
        longint av, bv, p, lim;
        logic [63:0] u;
        if (SG[k]) begin
            av = longint'($signed(a));
            bv = longint'($signed(b));
        end else begin
            av = longint'(a);
            bv = longint'(b);
        end
        p = av * bv;
        if (SAT && PW[k] < 20) begin
            if (SG[k]) begin
                lim = longint'(1) << (PW[k] - 1);
                if (p > lim - 1) p = lim - 1;
                else if (p < -lim) p = -lim;
            end else begin
                lim = longint'(1) << PW[k];
                if (p >= lim) p = lim - 1;
            end
        end
        u = p;
        u = u & ((64'd1 << PW[k]) - 64'd1);
        return u[19:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Observes the handshake values that the coming rising edge will act on.
    task automatic sb();
        logic exp_ir;
        for (int k = 0; k < 4; k++) begin
            exp_ir = ce && !(ov[k] && !out_ready);
            chk($sformatf("in_ready%0d", k), 32'(ir[k]), 32'(exp_ir));
            if (hold_v[k]) begin
                chk($sformatf("hold_valid%0d", k), 32'(ov[k]), 32'(prev_ov[k]));
                chk($sformatf("hold_dout%0d", k), 32'(dv[k]), 32'(prev_dv[k]));
            end
            if (reset && in_valid && ir[k])
                expq[k].push_back(model(k, din0, din1));
            if (reset && ov[k] && out_ready && ce) begin
                chk($sformatf("expected_pending%0d", k), 32'(expq[k].size() != 0), 32'd1);
                if (expq[k].size() != 0)
                    chk($sformatf("stream_dout%0d", k), 32'(dv[k]), 32'(expq[k].pop_front()));
            end
            hold_v[k]  = reset && !exp_ir;
            prev_ov[k] = ov[k];
            prev_dv[k] = dv[k];
        end
    endtask

    task automatic step();
        @(negedge clk);
        sb();
        @(posedge clk);
        #1;
    endtask

    task automatic single_beat(input logic [10:0] a, input logic [8:0] b,
                               input logic [19:0] e0, input logic [19:0] e1,
                               input logic [19:0] e2, input logic [19:0] e3);
        logic [19:0] e [4];
        e = '{e0, e1, e2, e3};
        ce = 1'b1; out_ready = 1'b1;
        din0 = a; din1 = b; in_valid = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            in_valid = 1'b0;
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("lat_valid%0d_c%0d", k, c), 32'(ov[k]), 32'(c == NS[k]));
                if (c == NS[k])
                    chk($sformatf("beat_dout%0d", k), 32'(dv[k]), 32'(e[k]));
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            hold_v[k] = 1'b0; prev_ov[k] = 1'b0; prev_dv[k] = '0;
        end
        reset = 1'b0; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        din0 = '0; din1 = '0;
        #12;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_valid%0d", k), 32'(ov[k]), 32'd0);
            chk($sformatf("rst_dout%0d", k), 32'(dv[k]), 32'd0);
            chk($sformatf("rst_ready%0d", k), 32'(ir[k]), 32'd1);
        end
        step(); step();
        reset = 1'b1;
        step();

        single_beat(11'd2047, 9'd511, 20'hFF601, 20'h00001,
                    SAT ? 20'h0FFFF : 20'h0F601, 20'h00001);
        single_beat(11'h400, 9'h100, 20'h40000, 20'h40000,
                    SAT ? 20'h0FFFF : 20'h00000, SAT ? 20'h07FFF : 20'h00000);
        single_beat(11'h400, 9'h0FF, 20'h3FC00, 20'hC0400,
                    SAT ? 20'h0FFFF : 20'h0FC00, SAT ? 20'h08000 : 20'h00400);

        // Full-rate stream: one result per cycle after exactly NS cycles.
        out_ready = 1'b1; ce = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = (i <= 10);
            din0 = 11'($urandom); din1 = 9'($urandom);
            step();
            for (int k = 0; k < 4; k++)
                chk($sformatf("rate_valid%0d_i%0d", k, i), 32'(ov[k]),
                    32'(i >= NS[k] && i <= NS[k] + 9));
        end

        // Random backpressure and clock-enable gaps.
        for (int i = 0; i < 120; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            ce        = ($urandom_range(0, 7) != 0);
            din0 = 11'($urandom); din1 = 9'($urandom);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1; ce = 1'b1;
        for (int i = 0; i < 10; i++) step();
        for (int k = 0; k < 4; k++)
            chk($sformatf("drain_left%0d", k), 32'(expq[k].size()), 32'd0);

        // Reset with beats in flight.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din0 = 11'($urandom); din1 = 9'($urandom);
            step();
        end
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            hold_v[k] = 1'b0;
            expq[k].delete();
        end
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("async_rst_valid%0d", k), 32'(ov[k]), 32'd0);
            chk($sformatf("async_rst_dout%0d", k), 32'(dv[k]), 32'd0);
        end
        step(); step();
        reset = 1'b1;
        step();
        single_beat(11'd2047, 9'd511, 20'hFF601, 20'h00001,
                    SAT ? 20'h0FFFF : 20'h0F601, 20'h00001);
        for (int k = 0; k < 4; k++)
            chk($sformatf("final_left%0d", k), 32'(expq[k].size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
